// File: rtl/tick_period_monitor.sv
// tick_period_monitor
// Receiving end of the game-timing strobe. Measures the number of clk_in
// cycles between consecutive tick rising edges and reports each period on a
// valid/ready port. Tracks whether recent periods sit within tolerance of
// the nominal period (locked) and flags a missing tick (timeout).
//
// Output handshake (period_valid / period_ready):
//   period_valid high means period_data holds a measurement not yet taken.
//   A cycle with period_valid=1 and period_ready=1 consumes it. period_data
//   stays stable while valid is high and unconsumed. A new measurement that
//   arrives while the old one is unconsumed overwrites it and pulses overrun.
//   A new measurement that arrives in a consume cycle simply replaces it, with
//   no overrun. period_ready while period_valid=0 has no effect.
module tick_period_monitor #(
    parameter int CNT_W    = 28,
    parameter int EXPECTED = 40000001,
    parameter int TOL      = 16,
    parameter int LOCK_N   = 4,
    parameter int TIMEOUT  = 48000000
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             tick_in,
    input  logic             period_ready,
    output logic [CNT_W-1:0] period_data,
    output logic             period_valid,
    output logic             overrun,
    output logic             locked,
    output logic             timeout
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_TIMEOUT = 2'd2
    } state_t;

    localparam logic signed [CNT_W:0] EXP_S     = (CNT_W+1)'(EXPECTED);
    localparam logic signed [CNT_W:0] TOL_S     = (CNT_W+1)'(TOL);
    localparam logic signed [CNT_W:0] NEG_TOL_S = -TOL_S;
    localparam logic [CNT_W-1:0]      TMO_C     = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]      ONE_C     = CNT_W'(1);
    localparam logic [3:0]            LOCK_C    = 4'(LOCK_N);

    state_t                  state;
    state_t                  state_next;
    logic                    tick_q;
    logic                    evt;
    logic [CNT_W-1:0]        cnt;
    logic [3:0]              match_cnt;
    logic [3:0]              match_next;
    logic                    emit;
    logic                    enter_timeout;
    logic signed [CNT_W:0]   diff;
    logic                    is_match;

    // A tick held high for several cycles counts as a single event.
    assign evt = tick_in & ~tick_q;

    // State register.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: the first edge only arms the measurement, later edges
    // emit a period, and a silent full TIMEOUT interval drops to ST_TIMEOUT.
    always_comb begin
        state_next    = state;
        emit          = 1'b0;
        enter_timeout = 1'b0;
        case (state)
            ST_IDLE: begin
                if (evt) state_next = ST_MEASURE;
            end
            ST_MEASURE: begin
                if (evt) begin
                    emit = 1'b1;
                end else if (cnt == TMO_C) begin
                    state_next    = ST_TIMEOUT;
                    enter_timeout = 1'b1;
                end
            end
            ST_TIMEOUT: begin
                if (evt) state_next = ST_MEASURE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Tolerance test on the period being emitted (cnt in the event cycle),
    // done signed so periods below EXPECTED compare correctly.
    always_comb begin
        diff       = $signed({1'b0, cnt}) - EXP_S;
        is_match   = (diff >= NEG_TOL_S) && (diff <= TOL_S);
        match_next = 4'd0;
        if (is_match) begin
            match_next = (match_cnt == LOCK_C) ? LOCK_C : match_cnt + 4'd1;
        end
    end

    // Period counter, output register and lock tracking.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            tick_q       <= 1'b0;
            cnt          <= '0;
            match_cnt    <= 4'd0;
            period_data  <= '0;
            period_valid <= 1'b0;
            overrun      <= 1'b0;
            locked       <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            tick_q  <= tick_in;
            timeout <= (state_next == ST_TIMEOUT);
            overrun <= emit & period_valid & ~period_ready;

            if (evt) begin
                cnt <= ONE_C;
            end else if (cnt != TMO_C) begin
                cnt <= cnt + ONE_C;
            end

            if (emit) begin
                period_data  <= cnt;
                period_valid <= 1'b1;
                match_cnt    <= match_next;
                locked       <= (match_next == LOCK_C);
            end else begin
                if (period_ready) period_valid <= 1'b0;
                if (enter_timeout) begin
                    match_cnt <= 4'd0;
                    locked    <= 1'b0;
                end
            end
        end
    end

endmodule
